// File: rtl/count_updown_nbits.sv
// ---------------------------------------------------------------------------
// count_updown_nbits
//   Parametrised synchronous up/down counter with programmable terminal count,
//   count enable, direction control, parallel load, wrap or saturate mode and
//   a combinational terminal-count output for building synchronous chains.
//
// Parameters
//   WIDTH      counter width in bits (>= 2)
//   MAX_COUNT  terminal count, 1 .. 2**WIDTH-1
//   WRAP       1 = wrap around at the bounds, 0 = saturate at the bounds
//
// Ports
//   clk       in   1      clock, all state changes on the rising edge
//   clr       in   1      synchronous active-high clear (highest priority)
//   en        in   1      count enable
//   up        in   1      direction: 1 = increment, 0 = decrement
//   load      in   1      parallel load strobe (overrides en)
//   load_val  in   WIDTH  load value, clamped to MAX_COUNT
//   q         out  WIDTH  registered count
//   out       out  1      terminal count / carry, combinational
//   sat       out  1      registered, high while held at a bound (WRAP=0)
// ---------------------------------------------------------------------------
module count_updown_nbits #(
   parameter int WIDTH     = 7,
   parameter int MAX_COUNT = (1 << WIDTH) - 1,
   parameter bit WRAP      = 1'b1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             out,
   output logic             sat
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

   logic [WIDTH-1:0] r_q;
   logic             r_sat;

   logic [WIDTH-1:0] w_q_nxt;
   logic             w_sat_nxt;
   logic [WIDTH-1:0] w_load_q;
   logic             w_at_top;
   logic             w_at_bot;

   assign w_at_top = (r_q == MAX_Q);
   assign w_at_bot = (r_q == '0);

   // Out-of-range load values clamp so q never leaves 0..MAX_COUNT.
   assign w_load_q = (load_val > MAX_Q) ? MAX_Q : load_val;

   // Next-state selection: load > en > hold (clr is applied in the register).
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      w_q_nxt   = r_q;
      w_sat_nxt = r_sat;
      if (load) begin
         w_q_nxt   = w_load_q;
         w_sat_nxt = 1'b0;
      end else if (en) begin
         if (up) begin
            if (!w_at_top) begin
               w_q_nxt   = r_q + ONE_Q;
               w_sat_nxt = 1'b0;
            end else if (WRAP) begin
               w_q_nxt   = '0;
               w_sat_nxt = 1'b0;
            end else begin
               w_sat_nxt = 1'b1;
            end
         end else begin
            if (!w_at_bot) begin
               w_q_nxt   = r_q - ONE_Q;
               w_sat_nxt = 1'b0;
            end else if (WRAP) begin
               w_q_nxt   = MAX_Q;
               w_sat_nxt = 1'b0;
            end else begin
               w_sat_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (clr) begin
         r_q   <= '0;
         r_sat <= 1'b0;
      end else begin
         r_q   <= w_q_nxt;
         r_sat <= w_sat_nxt;
      end
   end

   // Terminal count is combinational so a downstream stage enabled by it
   // steps on the very same edge this stage wraps, keeping chains synchronous.
   assign out = en & ~clr & ((up & w_at_top) | (~up & w_at_bot));
   assign q   = r_q;
   assign sat = r_sat;

endmodule

// File: tb/tb_count_updown_nbits.sv
// ---------------------------------------------------------------------------
// tb_count_updown_nbits
//   Directed self-checking bench for count_updown_nbits. Instances:
//     u_def  defaults (WIDTH 7, MAX 127, wrap)
//     u_m9w  MAX 9, wrap
//     u_m9s  MAX 9, saturate
//     u_m99  WIDTH 8, MAX 99, wrap
//     u_c0/u_c1  defaults, cascaded through out -> en
// ---------------------------------------------------------------------------
module tb_count_updown_nbits;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clr;

   logic       d_en, d_up, d_load;  logic [6:0] d_lv;  logic [6:0] d_q;  logic d_out, d_sat;
   logic       w_en, w_up, w_load;  logic [6:0] w_lv;  logic [6:0] w_q;  logic w_out, w_sat;
   logic       s_en, s_up, s_load;  logic [6:0] s_lv;  logic [6:0] s_q;  logic s_out, s_sat;
   logic       m_en, m_up, m_load;  logic [7:0] m_lv;  logic [7:0] m_q;  logic m_out, m_sat;
   logic       c0_en, c0_load;      logic [6:0] c0_lv; logic [6:0] c0_q; logic c0_out, c0_sat;
   logic       c1_load;             logic [6:0] c1_lv; logic [6:0] c1_q; logic c1_out, c1_sat;

   int n_cmp = 0;
   int n_err = 0;

   count_updown_nbits u_def (
      .clk(clk), .clr(clr), .en(d_en), .up(d_up), .load(d_load), .load_val(d_lv),
      .q(d_q), .out(d_out), .sat(d_sat));

   count_updown_nbits #(.MAX_COUNT(9), .WRAP(1'b1)) u_m9w (
      .clk(clk), .clr(clr), .en(w_en), .up(w_up), .load(w_load), .load_val(w_lv),
      .q(w_q), .out(w_out), .sat(w_sat));

   count_updown_nbits #(.MAX_COUNT(9), .WRAP(1'b0)) u_m9s (
      .clk(clk), .clr(clr), .en(s_en), .up(s_up), .load(s_load), .load_val(s_lv),
      .q(s_q), .out(s_out), .sat(s_sat));

   count_updown_nbits #(.WIDTH(8), .MAX_COUNT(99), .WRAP(1'b1)) u_m99 (
      .clk(clk), .clr(clr), .en(m_en), .up(m_up), .load(m_load), .load_val(m_lv),
      .q(m_q), .out(m_out), .sat(m_sat));

   count_updown_nbits u_c0 (
      .clk(clk), .clr(clr), .en(c0_en), .up(1'b1), .load(c0_load), .load_val(c0_lv),
      .q(c0_q), .out(c0_out), .sat(c0_sat));

   count_updown_nbits u_c1 (
      .clk(clk), .clr(clr), .en(c0_out), .up(1'b1), .load(c1_load), .load_val(c1_lv),
      .q(c1_q), .out(c1_out), .sat(c1_sat));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [13:0] model;
   logic [13:0] prev;

   initial begin
      clr = 1'b1;
      d_en = 1'b0; d_up = 1'b1; d_load = 1'b0; d_lv = '0;
      w_en = 1'b0; w_up = 1'b1; w_load = 1'b0; w_lv = '0;
      s_en = 1'b0; s_up = 1'b1; s_load = 1'b0; s_lv = '0;
      m_en = 1'b0; m_up = 1'b1; m_load = 1'b0; m_lv = '0;
      c0_en = 1'b0; c0_load = 1'b0; c0_lv = '0;
      c1_load = 1'b0; c1_lv = '0;

      // ---- 1: clear for two cycles; out gated by clr even at q==0, up=0
      tick();
      d_en = 1'b1; d_up = 1'b0;
      #1;
      check("t1_out_during_clr", 32'(d_out), 0);
      tick();
      check("t1_q_after_clr", 32'(d_q), 0);
      check("t1_sat_after_clr", 32'(d_sat), 0);
      clr = 1'b0; d_en = 1'b0; d_up = 1'b1;
      #1;
      check("t1_out_en0", 32'(d_out), 0);
      tick(); tick();
      check("t1_q_hold", 32'(d_q), 0);
      check("t1_sat_hold", 32'(d_sat), 0);

      // ---- 2: defaults count 0..127, out at 127, wrap to 0
      d_en = 1'b1; d_up = 1'b1;
      for (int i = 1; i <= 127; i++) begin
         tick();
         check("t2_count", 32'(d_q), 32'(i));
      end
      check("t2_out_at_max", 32'(d_out), 1);
      tick();
      check("t2_wrap_q", 32'(d_q), 0);
      check("t2_out_after_wrap", 32'(d_out), 0);
      d_en = 1'b0;

      // ---- 3a: MAX 9 wrap, down from 0 -> 9, up from 9 -> 0
      w_en = 1'b1; w_up = 1'b0;
      #1;
      check("t3w_out_at_0", 32'(w_out), 1);
      tick();
      check("t3w_q_wrap_down", 32'(w_q), 9);
      check("t3w_out_at_9_down", 32'(w_out), 0);
      w_up = 1'b1;
      #1;
      check("t3w_out_at_9_up", 32'(w_out), 1);
      tick();
      check("t3w_q_wrap_up", 32'(w_q), 0);
      check("t3w_sat", 32'(w_sat), 0);
      w_en = 1'b0;

      // ---- 3b: MAX 9 saturate at 0, turn around, clamp load, saturate at 9
      s_en = 1'b1; s_up = 1'b0;
      #1;
      check("t3s_out_at_0", 32'(s_out), 1);
      tick();
      check("t3s_q_held_0", 32'(s_q), 0);
      check("t3s_sat_set_0", 32'(s_sat), 1);
      tick();
      check("t3s_q_still_0", 32'(s_q), 0);
      check("t3s_sat_still", 32'(s_sat), 1);
      s_up = 1'b1;
      tick();
      check("t3s_q_turnaround", 32'(s_q), 1);
      check("t3s_sat_cleared", 32'(s_sat), 0);
      s_load = 1'b1; s_lv = 7'd100;
      tick();
      check("t3s_load_clamp", 32'(s_q), 9);
      check("t3s_load_sat", 32'(s_sat), 0);
      s_load = 1'b0;
      #1;
      check("t3s_out_at_9", 32'(s_out), 1);
      tick();
      check("t3s_q_held_9", 32'(s_q), 9);
      check("t3s_sat_set_9", 32'(s_sat), 1);
      s_up = 1'b0;
      tick();
      check("t3s_q_down_from_9", 32'(s_q), 8);
      check("t3s_sat_clear_9", 32'(s_sat), 0);
      s_en = 1'b0;

      // ---- 4: WIDTH 8, MAX 99: load clamp, load beats en
      m_en = 1'b1; m_up = 1'b1; m_load = 1'b1; m_lv = 8'd200;
      tick();
      check("t4_load_clamp", 32'(m_q), 99);
      m_lv = 8'd5;
      tick();
      check("t4_load_over_en", 32'(m_q), 5);
      m_load = 1'b0;
      tick();
      check("t4_count_after_load", 32'(m_q), 6);
      m_en = 1'b0;

      // ---- 5: clr beats load mid-count, counting resumes from 0
      d_load = 1'b1; d_lv = 7'd42;
      tick();
      check("t5_loaded", 32'(d_q), 42);
      clr = 1'b1; d_lv = 7'd7; d_en = 1'b1; d_up = 1'b1;
      tick();
      check("t5_clr_over_load", 32'(d_q), 0);
      clr = 1'b0; d_load = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("t5_resume", 32'(d_q), 32'(i));
      end
      d_en = 1'b0;

      // ---- 6: cascade; start near stage0 wrap and cross three wraps
      c0_load = 1'b1; c0_lv = 7'd120; c1_load = 1'b1; c1_lv = 7'd0;
      tick();
      c0_load = 1'b0; c1_load = 1'b0;
      model = 14'd120;
      check("t6_preload", 32'({c1_q, c0_q}), 32'(model));
      c0_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         prev = {c1_q, c0_q};
         tick();
         model = model + 14'd1;
         check("t6_chain", 32'({c1_q, c0_q}), 32'(model));
         check("t6_monotonic", 32'({c1_q, c0_q} > prev), 1);
      end
      check("t6_stage1_final", 32'(c1_q), 3);
      c0_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
